core_dispatch_ctrl: RTL

Dual-queue dispatch controller between the instruction arbiter and the two execution cores. Buffers each routed instruction in the selected core's queue and hands it to that core over a valid/ready handshake. Enforces cross-core barrier ordering: an instruction with the sync bit set does not issue until the other core has issued every instruction routed to it earlier. Reports occupancy and a sticky protocol-error flag.

---
 rtl/core_dispatch_ctrl_pkg.sv | 13 +
 rtl/core_dispatch_ctrl_if.sv | 35 +++
 rtl/core_dispatch_ctrl_fifo.sv | 67 ++++++
 rtl/core_dispatch_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/core_dispatch_ctrl_pkg.sv
// Shared constants and queue entry type for the dual-core dispatch controller.
package dispatch_pkg;

  localparam int unsigned DISP_DEPTH    = 8;
  localparam int unsigned DISP_CNT_W    = 8;
  localparam int unsigned DISP_SYNC_BIT = 31;

  typedef struct packed {
    logic [31:0]           instr;
    logic [DISP_CNT_W-1:0] snap;
  } disp_entry_t;

endpackage

// File: rtl/core_dispatch_ctrl_if.sv
// Arbiter/core-facing bundle of the dispatch controller; master is the environment side.
interface core_dispatch_ctrl_if
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = DISP_DEPTH
);

  logic [31:0]                instr_in;
  logic                       FIFO_1_en;
  logic                       FIFO_2_en;
  logic                       in_ready1;
  logic                       in_ready2;
  logic [31:0]                core1_instr;
  logic [31:0]                core2_instr;
  logic                       core1_valid;
  logic                       core2_valid;
  logic                       core1_ready;
  logic                       core2_ready;
  logic [$clog2(DEPTH+1)-1:0] count1;
  logic [$clog2(DEPTH+1)-1:0] count2;
  logic                       err;

  modport master (
    output instr_in, FIFO_1_en, FIFO_2_en, core1_ready, core2_ready,
    input  in_ready1, in_ready2, core1_instr, core2_instr,
           core1_valid, core2_valid, count1, count2, err
  );

  modport slave (
    input  instr_in, FIFO_1_en, FIFO_2_en, core1_ready, core2_ready,
    output in_ready1, in_ready2, core1_instr, core2_instr,
           core1_valid, core2_valid, count1, count2, err
  );

endinterface

// File: rtl/core_dispatch_ctrl_fifo.sv
// Per-core circular instruction queue with wrapping enqueue/issue counters.
module dispatch_fifo
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = DISP_DEPTH,
  parameter int unsigned CNT_W = DISP_CNT_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [31:0]                wr_instr,
  input  logic [CNT_W-1:0]           wr_snap,
  input  logic                       rd_en,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                head_instr,
  output logic [CNT_W-1:0]           head_snap,
  output logic [CNT_W-1:0]           enq_cnt,
  output logic [CNT_W-1:0]           iss_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  disp_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      mem[wr_ptr] <= '{instr: wr_instr, snap: wr_snap};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      enq_cnt <= '0;
      iss_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        enq_cnt <= enq_cnt + CNT_W'(1);
      end
      if (rd_en) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        iss_cnt <= iss_cnt + CNT_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    full       = (count == OCC_W'(DEPTH));
    empty      = (count == '0);
    head_instr = mem[rd_ptr].instr;
    head_snap  = mem[rd_ptr].snap;
  end

endmodule

// File: rtl/core_dispatch_ctrl.sv
// Dual-queue dispatch controller: write decode, sticky protocol error and
// cross-core barrier gating of each queue head.
module core_dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH    = DISP_DEPTH,
  parameter int unsigned CNT_W    = DISP_CNT_W,
  parameter int unsigned SYNC_BIT = DISP_SYNC_BIT
) (
  input  logic                 clk,
  input  logic                 resetn,
  core_dispatch_ctrl_if.slave  bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic             full1, full2, empty1, empty2;
  logic [31:0]      head_instr1, head_instr2;
  logic [CNT_W-1:0] head_snap1, head_snap2;
  logic [CNT_W-1:0] enq_cnt1, enq_cnt2, iss_cnt1, iss_cnt2;
  logic [OCC_W-1:0] cnt1, cnt2;
  logic [CNT_W-1:0] lag1, lag2;
  logic             bad_wr, wr1, wr2, rd1, rd2;
  logic             blocked1, blocked2, valid1, valid2;
  logic             err_q;

  always_comb begin
    bad_wr = (bus.FIFO_1_en && bus.FIFO_2_en) ||
             (bus.FIFO_1_en && full1) ||
             (bus.FIFO_2_en && full2);
    wr1 = bus.FIFO_1_en && !bad_wr;
    wr2 = bus.FIFO_2_en && !bad_wr;
    // Counters wrap, so "other core still behind the snapshot" is the sign of the modular difference.
    lag1     = iss_cnt2 - head_snap1;
    lag2     = iss_cnt1 - head_snap2;
    blocked1 = head_instr1[SYNC_BIT] && lag1[CNT_W-1];
    blocked2 = head_instr2[SYNC_BIT] && lag2[CNT_W-1];
    valid1   = !empty1 && !blocked1;
    valid2   = !empty2 && !blocked2;
    rd1      = valid1 && bus.core1_ready;
    rd2      = valid2 && bus.core2_ready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (bad_wr) begin
      err_q <= 1'b1;
    end
  end

  dispatch_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo1 (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr1),
    .wr_instr   (bus.instr_in),
    .wr_snap    (enq_cnt2),
    .rd_en      (rd1),
    .full       (full1),
    .empty      (empty1),
    .count      (cnt1),
    .head_instr (head_instr1),
    .head_snap  (head_snap1),
    .enq_cnt    (enq_cnt1),
    .iss_cnt    (iss_cnt1)
  );

  dispatch_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo2 (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr2),
    .wr_instr   (bus.instr_in),
    .wr_snap    (enq_cnt1),
    .rd_en      (rd2),
    .full       (full2),
    .empty      (empty2),
    .count      (cnt2),
    .head_instr (head_instr2),
    .head_snap  (head_snap2),
    .enq_cnt    (enq_cnt2),
    .iss_cnt    (iss_cnt2)
  );

  always_comb begin
    bus.in_ready1   = !full1;
    bus.in_ready2   = !full2;
    bus.core1_instr = head_instr1;
    bus.core2_instr = head_instr2;
    bus.core1_valid = valid1;
    bus.core2_valid = valid2;
    bus.count1      = cnt1;
    bus.count2      = cnt2;
    bus.err         = err_q;
  end

endmodule
